ex_muldiv: RTL

Parametrised multi-cycle multiply/divide unit for the EX stage of the MIPS pipeline.
- Executes MULT, MULTU, DIV and DIVU and produces a HI/LO result pair.
- Raises a stall request toward the pipeline controller while an operation is in flight.
- Supports flush-on-exception through cancel_i.
- Sits beside the EX ALU; the HI/LO result goes to the HI/LO write path in MEM/WB.

---
 rtl/ex_muldiv.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage; produces a HI/LO pair
// and holds the pipeline with stallreq_o while an operation is in flight.
module ex_muldiv #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             cancel_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             stallreq_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             sgn_q;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rem_q;

    logic               is_signed_in;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_sgn;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     rem_sh;
    logic               ge;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    assign is_signed_in = ~op_i[0];
    assign abs_a = (is_signed_in && opa_i[WIDTH-1]) ? -opa_i : opa_i;
    assign abs_b = (is_signed_in && opb_i[WIDTH-1]) ? -opb_i : opb_i;

    // Operands come straight from the ports when the product is needed on accept
    assign mul_a   = (state == IDLE) ? opa_i : a_q;
    assign mul_b   = (state == IDLE) ? opb_i : b_q;
    assign mul_sgn = (state == IDLE) ? is_signed_in : sgn_q;
    assign ext_a   = {{WIDTH{mul_sgn & mul_a[WIDTH-1]}}, mul_a};
    assign ext_b   = {{WIDTH{mul_sgn & mul_b[WIDTH-1]}}, mul_b};
    assign prod    = ext_a * ext_b;

    // One restoring step: a_q shifts the dividend out and the quotient bits in
    assign rem_sh = {rem_q, a_q[WIDTH-1]};
    assign ge     = (rem_sh >= {1'b0, b_q});
    assign rem_nx = ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
    assign quo_nx = {a_q[WIDTH-2:0], ge};
    assign q_fix  = neg_q ? -quo_nx : quo_nx;
    assign r_fix  = neg_r ? -rem_nx : rem_nx;

    assign done_o     = (state == DONE);
    assign busy_o     = (state == MUL) || (state == DIV);
    assign stallreq_o = ~cancel_i & (busy_o | ((state == IDLE) & start_i));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sgn_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            rem_q <= '0;
            hi_o  <= '0;
            lo_o  <= '0;
        end else if (cancel_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        cnt   <= '0;
                        sgn_q <= is_signed_in;
                        if (!op_i[1]) begin
                            a_q <= opa_i;
                            b_q <= opb_i;
                            if (MUL_CYCLES == 1) begin
                                hi_o  <= prod[2*WIDTH-1:WIDTH];
                                lo_o  <= prod[WIDTH-1:0];
                                state <= DONE;
                            end else begin
                                state <= MUL;
                            end
                        end else if (opb_i == '0) begin
                            hi_o  <= opa_i;
                            lo_o  <= '1;
                            state <= DONE;
                        end else begin
                            a_q   <= abs_a;
                            b_q   <= abs_b;
                            rem_q <= '0;
                            neg_q <= is_signed_in & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                            neg_r <= is_signed_in & opa_i[WIDTH-1];
                            state <= DIV;
                        end
                    end
                end
                MUL: begin
                    if (cnt == CW'(MUL_CYCLES - 2)) begin
                        hi_o  <= prod[2*WIDTH-1:WIDTH];
                        lo_o  <= prod[WIDTH-1:0];
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DIV: begin
                    a_q   <= quo_nx;
                    rem_q <= rem_nx;
                    if (cnt == CW'(WIDTH - 1)) begin
                        hi_o  <= r_fix;
                        lo_o  <= q_fix;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
